// File: rtl/data_mem_pkg.sv
// Shared encodings and helpers for the byte-addressable data memory.
// Optional clear engine is selected with DATA_MEM_CLEAR_EN.
package data_mem_pkg;

   localparam logic [1:0] SZ_BYTE   = 2'b00;
   localparam logic [1:0] SZ_HALF   = 2'b01;
   localparam logic [1:0] SZ_WORD   = 2'b10;
   localparam logic [1:0] SZ_DOUBLE = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Lane is zero-padded to 3 bits so one check serves both word widths.
   function automatic logic data_mem_misaligned(input logic [1:0] size,
                                                input logic [2:0] lane,
                                                input logic       wide64);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lane[0];
         SZ_WORD: bad = |lane[1:0];
         default: bad = (|lane) | ~wide64;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Byte-lane steering: write enables and shifted store data, plus load
// extraction with sign/zero extension. Purely combinational.
module data_mem_lane_align
   import data_mem_pkg::*;
#(
   parameter int WIDTH = 32,
   localparam int NB   = WIDTH / 8,
   localparam int OFS  = $clog2(NB)
) (
   input  logic [OFS-1:0]   i_lane,
   input  logic [1:0]       i_size,
   input  logic             i_unsigned,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [WIDTH-1:0] i_word,
   output logic [NB-1:0]    o_byteEn,
   output logic [WIDTH-1:0] o_wdata,
   output logic [WIDTH-1:0] o_rdata
);

   logic [NB-1:0]    w_mask;
   logic [WIDTH-1:0] w_shifted;

   always_comb begin
      w_mask = '0;
      case (i_size)
         SZ_BYTE: w_mask = NB'(1);
         SZ_HALF: w_mask = NB'(3);
         SZ_WORD: w_mask = NB'(15);
         default: w_mask = '1;
      endcase
      o_byteEn  = w_mask << i_lane;
      o_wdata   = i_wdata << {i_lane, 3'b000};
      w_shifted = i_word >> {i_lane, 3'b000};
   end

   // Word loads extend from bit 31 even when the array is 64 bits wide.
   always_comb begin
      o_rdata = '0;
      case (i_size)
         SZ_BYTE: o_rdata = i_unsigned ? WIDTH'(w_shifted[7:0])
                                       : WIDTH'($signed(w_shifted[7:0]));
         SZ_HALF: o_rdata = i_unsigned ? WIDTH'(w_shifted[15:0])
                                       : WIDTH'($signed(w_shifted[15:0]));
         SZ_WORD: o_rdata = i_unsigned ? WIDTH'(w_shifted[31:0])
                                       : WIDTH'($signed(w_shifted[31:0]));
         default: o_rdata = w_shifted;
      endcase
   end

endmodule

// File: rtl/data_mem_byte.sv
// Byte-addressable data memory for the single-cycle MIPS datapath.
// Define DATA_MEM_CLEAR_EN to include the post-reset clear sweep.
module data_mem_byte
   import data_mem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 128,
   parameter int AD_WIDTH   = 32,
   parameter int TEST_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  Res,
   input  logic [AD_WIDTH-1:0]   Address,
   input  logic [WIDTH-1:0]      WData,
   input  logic [1:0]            Size,
   input  logic                  Unsigned,
   input  logic                  Rd_En,
   input  logic                  Wr_En,
   output logic [WIDTH-1:0]      RData,
   output logic                  Busy,
   output logic                  Misaligned,
   output logic                  Fault,
   output logic [TEST_WIDTH-1:0] Test_value
);

   localparam int NB  = WIDTH / 8;
   localparam int OFS = $clog2(NB);
   localparam int IDX = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             r_fault;

   logic [IDX-1:0]   w_index;
   logic [OFS-1:0]   w_lane;
   logic             w_misaligned;
   logic             w_busy;
   logic             w_storeEn;
   logic             w_clrWrite;
   logic [IDX-1:0]   w_clrIdx;
   logic [NB-1:0]    w_byteEn;
   logic [WIDTH-1:0] w_wdataSteered;
   logic [WIDTH-1:0] w_loadData;
   logic             w_unusedAddr;

   assign w_index      = Address[OFS+IDX-1:OFS];
   assign w_lane       = Address[OFS-1:0];
   assign w_unusedAddr = ^Address[AD_WIDTH-1:OFS+IDX];
   assign w_misaligned = data_mem_misaligned(Size, 3'(w_lane), WIDTH == 64);

`ifdef DATA_MEM_CLEAR_EN
   state_e         r_state;
   state_e         w_nextState;
   logic [IDX-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (Res) begin
         r_state <= ST_CLEAR;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nextState;
         if (r_state == ST_CLEAR)
            r_cnt <= r_cnt + IDX'(1);
      end
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_CLEAR: if (r_cnt == IDX'(DEPTH - 1)) w_nextState = ST_READY;
         default:  w_nextState = r_state;
      endcase
   end

   // Holding Res keeps rewriting word 0, so the sweep restarts cleanly.
   assign w_busy     = Res | (r_state == ST_CLEAR);
   assign w_clrWrite = w_busy;
   assign w_clrIdx   = Res ? '0 : r_cnt;
`else
   assign w_busy     = 1'b0;
   assign w_clrWrite = 1'b0;
   assign w_clrIdx   = '0;
`endif

   data_mem_lane_align #(.WIDTH(WIDTH)) u_align (
      .i_lane     (w_lane),
      .i_size     (Size),
      .i_unsigned (Unsigned),
      .i_wdata    (WData),
      .i_word     (r_mem[w_index]),
      .o_byteEn   (w_byteEn),
      .o_wdata    (w_wdataSteered),
      .o_rdata    (w_loadData)
   );

   assign w_storeEn = Wr_En & ~w_busy & ~w_misaligned;

   always_ff @(posedge clk) begin
      if (w_clrWrite) begin
         r_mem[w_clrIdx] <= '0;
      end else if (w_storeEn) begin
         for (int b = 0; b < NB; b++)
            if (w_byteEn[b]) r_mem[w_index][b*8 +: 8] <= w_wdataSteered[b*8 +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (Res)
         r_fault <= 1'b0;
      else if (!w_busy && w_misaligned && (Wr_En || Rd_En))
         r_fault <= 1'b1;
   end

   assign RData      = (w_busy | w_misaligned) ? '0 : w_loadData;
   assign Busy       = w_busy;
   assign Misaligned = w_misaligned;
   assign Fault      = r_fault;
   assign Test_value = r_mem[0][TEST_WIDTH-1:0];

endmodule

// File: tb/tb_data_mem_byte.sv
// Self-checking bench for data_mem_byte using a byte-array reference model.
// Sweep scenarios are built only when DATA_MEM_CLEAR_EN is defined.
module tb_data_mem_byte;

   localparam int WIDTH      = 32;
   localparam int DEPTH      = 128;
   localparam int AD_WIDTH   = 32;
   localparam int TEST_WIDTH = 16;
   localparam int MEMB       = DEPTH * WIDTH / 8;

   logic                  clk = 1'b0;
   logic                  Res = 1'b1;
   logic [AD_WIDTH-1:0]   Address = '0;
   logic [WIDTH-1:0]      WData = '0;
   logic [1:0]            Size = 2'b10;
   logic                  Unsigned = 1'b0;
   logic                  Rd_En = 1'b0;
   logic                  Wr_En = 1'b0;
   logic [WIDTH-1:0]      RData;
   logic                  Busy;
   logic                  Misaligned;
   logic                  Fault;
   logic [TEST_WIDTH-1:0] Test_value;

   int nVectors     = 0;
   int nMiscompares = 0;

   logic [7:0] mdlBytes [MEMB];
   logic       mdlFault = 1'b0;

   data_mem_byte #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AD_WIDTH(AD_WIDTH), .TEST_WIDTH(TEST_WIDTH)
   ) dut (
      .clk(clk), .Res(Res), .Address(Address), .WData(WData), .Size(Size),
      .Unsigned(Unsigned), .Rd_En(Rd_En), .Wr_En(Wr_En), .RData(RData),
      .Busy(Busy), .Misaligned(Misaligned), .Fault(Fault), .Test_value(Test_value)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference model: memory as a flat byte array, accesses as byte runs.
   function automatic int accBytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic mdlMisaligned(input logic [31:0] addr, input logic [1:0] sz);
      if (sz == 2'b11) return 1'b1;
      return (addr % accBytes(sz)) != 0;
   endfunction

   function automatic logic [31:0] mdlLoad(input logic [31:0] addr, input logic [1:0] sz,
                                           input logic uns);
      logic [31:0] v;
      int n, base;
      if (mdlMisaligned(addr, sz)) return 32'h0;
      n = accBytes(sz);
      base = int'(addr % MEMB);
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mdlBytes[base + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      return v;
   endfunction

   function automatic logic [15:0] mdlTestValue();
      return {mdlBytes[1], mdlBytes[0]};
   endfunction

   task automatic mdlCommit(input logic [31:0] addr, input logic [1:0] sz, input logic rd,
                            input logic wr, input logic [31:0] data);
      logic mis;
      mis = mdlMisaligned(addr, sz);
      if (mis && (rd || wr)) mdlFault = 1'b1;
      if (wr && !mis)
         for (int i = 0; i < accBytes(sz); i++)
            mdlBytes[int'(addr % MEMB) + i] = data[8*i +: 8];
   endtask

   task automatic mdlClear();
      for (int i = 0; i < MEMB; i++) mdlBytes[i] = 8'h00;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [1:0] sz, input logic uns,
                        input logic rd, input logic wr, input logic [31:0] data);
      Address = addr; Size = sz; Unsigned = uns; Rd_En = rd; Wr_En = wr; WData = data;
   endtask

   task automatic idle();
      Rd_En = 1'b0; Wr_En = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic doStore(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] data);
      drive(addr, sz, 1'b0, 1'b0, 1'b1, data);
      mdlCommit(addr, sz, 1'b0, 1'b1, data);
      step();
      idle();
   endtask

   task automatic setLoad(input logic [31:0] addr, input logic [1:0] sz, input logic uns);
      drive(addr, sz, uns, 1'b1, 1'b0, 32'h0);
      #1;
   endtask

   task automatic waitReady(output int n);
      n = 0;
`ifdef DATA_MEM_CLEAR_EN
      do begin
         step();
         n++;
      end while (Busy === 1'b1 && n < 1000);
`endif
   endtask

   task automatic doReset(input int cycles, output int n);
      idle();
      Res = 1'b1;
      repeat (cycles) step();
      Res = 1'b0;
      mdlFault = 1'b0;
`ifdef DATA_MEM_CLEAR_EN
      mdlClear();
`endif
      waitReady(n);
   endtask

   task automatic test_reset();
      int n;
      Res = 1'b1;
      idle();
      repeat (3) step();
      nVectors++;
      if (Fault !== 1'b0) begin
         nMiscompares++; $display("FAIL reset_fault: got %b expected 0", Fault);
      end
`ifdef DATA_MEM_CLEAR_EN
      nVectors++;
      if (Busy !== 1'b1) begin
         nMiscompares++; $display("FAIL reset_busy: got %b expected 1", Busy);
      end
      setLoad(32'h0, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h0) begin
         nMiscompares++; $display("FAIL reset_rdata: got %h expected 0", RData);
      end
      idle();
      Res = 1'b0;
      mdlClear();
      waitReady(n);
      nVectors++;
      if (n != DEPTH) begin
         nMiscompares++; $display("FAIL reset_sweep_len: got %0d expected %0d", n, DEPTH);
      end
      nVectors++;
      if (Test_value !== 16'h0) begin
         nMiscompares++; $display("FAIL reset_test_value: got %h expected 0", Test_value);
      end
`else
      nVectors++;
      if (Busy !== 1'b0) begin
         nMiscompares++; $display("FAIL reset_busy: got %b expected 0", Busy);
      end
      Res = 1'b0;
      mdlFault = 1'b0;
      n = 0;
`endif
   endtask

   task automatic test_init();
      logic [31:0] a, exp;
      for (int w = 0; w < DEPTH; w++) doStore(32'(w * 4), 2'b10, $urandom);
      for (int k = 0; k < 8; k++) begin
         a = 32'($urandom_range(0, DEPTH - 1) * 4);
         setLoad(a, 2'b10, 1'b0);
         exp = mdlLoad(a, 2'b10, 1'b0);
         nVectors++;
         if (RData !== exp) begin
            nMiscompares++; $display("FAIL init_lw @%h: got %h expected %h", a, RData, exp);
         end
      end
      idle();
   endtask

   task automatic test_byte_lanes();
      doStore(32'h20, 2'b10, 32'h11223344);
      doStore(32'h21, 2'b00, 32'h000000AA);
      setLoad(32'h20, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h1122AA44) begin
         nMiscompares++; $display("FAIL lane_lw: got %h expected 1122aa44", RData);
      end
      setLoad(32'h21, 2'b00, 1'b0);
      nVectors++;
      if (RData !== 32'hFFFFFFAA) begin
         nMiscompares++; $display("FAIL lane_lb: got %h expected ffffffaa", RData);
      end
      setLoad(32'h21, 2'b00, 1'b1);
      nVectors++;
      if (RData !== 32'h000000AA) begin
         nMiscompares++; $display("FAIL lane_lbu: got %h expected 000000aa", RData);
      end
      idle();
   endtask

   task automatic test_half();
      doStore(32'h40, 2'b10, 32'h0);
      doStore(32'h42, 2'b01, 32'h00008001);
      setLoad(32'h40, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h80010000) begin
         nMiscompares++; $display("FAIL half_lw: got %h expected 80010000", RData);
      end
      setLoad(32'h42, 2'b01, 1'b0);
      nVectors++;
      if (RData !== 32'hFFFF8001) begin
         nMiscompares++; $display("FAIL half_lh: got %h expected ffff8001", RData);
      end
      setLoad(32'h42, 2'b01, 1'b1);
      nVectors++;
      if (RData !== 32'h00008001) begin
         nMiscompares++; $display("FAIL half_lhu: got %h expected 00008001", RData);
      end
      idle();
   endtask

   task automatic test_misalign();
      int n;
      drive(32'h23, 2'b10, 1'b0, 1'b0, 1'b1, 32'h55555555);
      #1;
      nVectors++;
      if (Misaligned !== 1'b1) begin
         nMiscompares++; $display("FAIL mis_flag: got %b expected 1", Misaligned);
      end
      mdlCommit(32'h23, 2'b10, 1'b0, 1'b1, 32'h55555555);
      step();
      idle();
      nVectors++;
      if (Fault !== 1'b1) begin
         nMiscompares++; $display("FAIL mis_fault_set: got %b expected 1", Fault);
      end
      setLoad(32'h20, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h1122AA44) begin
         nMiscompares++; $display("FAIL mis_no_write: got %h expected 1122aa44", RData);
      end
      setLoad(32'h21, 2'b01, 1'b0);
      nVectors++;
      if (RData !== 32'h0 || Misaligned !== 1'b1) begin
         nMiscompares++; $display("FAIL mis_lh: got %h/%b expected 0/1", RData, Misaligned);
      end
      idle();
      repeat (5) step();
      nVectors++;
      if (Fault !== 1'b1) begin
         nMiscompares++; $display("FAIL mis_fault_sticky: got %b expected 1", Fault);
      end
      doReset(2, n);
      nVectors++;
      if (Fault !== 1'b0) begin
         nMiscompares++; $display("FAIL mis_fault_clear: got %b expected 0", Fault);
      end
   endtask

   task automatic test_wrap();
      doStore(32'h200, 2'b10, 32'h0000BEEF);
      nVectors++;
      if (Test_value !== 16'hBEEF) begin
         nMiscompares++; $display("FAIL wrap_test_value: got %h expected beef", Test_value);
      end
      setLoad(32'h0, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h0000BEEF) begin
         nMiscompares++; $display("FAIL wrap_lw0: got %h expected 0000beef", RData);
      end
      idle();
   endtask

`ifdef DATA_MEM_CLEAR_EN
   task automatic test_sweep();
      int n;
      doStore(32'h10, 2'b10, 32'hDEADBEEF);
      setLoad(32'h10, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'hDEADBEEF) begin
         nMiscompares++; $display("FAIL sweep_pre: got %h expected deadbeef", RData);
      end
      doReset(3, n);
      nVectors++;
      if (n != DEPTH) begin
         nMiscompares++; $display("FAIL sweep_len: got %0d expected %0d", n, DEPTH);
      end
      setLoad(32'h10, 2'b10, 1'b0);
      nVectors++;
      if (RData !== 32'h0) begin
         nMiscompares++; $display("FAIL sweep_cleared: got %h expected 0", RData);
      end
      // First sweep: misaligned store must not raise Fault while Busy.
      idle();
      Res = 1'b1;
      step();
      Res = 1'b0;
      drive(32'h3, 2'b10, 1'b0, 1'b1, 1'b1, 32'h12345678);
      repeat (50) step();
      nVectors++;
      if (Fault !== 1'b0 || Busy !== 1'b1 || RData !== 32'h0) begin
         nMiscompares++;
         $display("FAIL sweep_busy_state: got F%b B%b %h expected F0 B1 0", Fault, Busy, RData);
      end
      // Mid-sweep reset, with an aligned store to word 0 held the whole time.
      Res = 1'b1;
      step();
      Res = 1'b0;
      drive(32'h0, 2'b10, 1'b0, 1'b1, 1'b1, 32'hCAFEF00D);
      waitReady(n);
      idle();
      mdlClear();
      mdlFault = 1'b0;
      nVectors++;
      if (n != DEPTH) begin
         nMiscompares++; $display("FAIL sweep_restart_len: got %0d expected %0d", n, DEPTH);
      end
      nVectors++;
      if (Test_value !== 16'h0 || Fault !== 1'b0) begin
         nMiscompares++;
         $display("FAIL sweep_busy_write: got %h/%b expected 0/0", Test_value, Fault);
      end
   endtask
`endif

   task automatic test_random();
      logic [31:0] a, d, exp;
      logic [1:0]  sz;
      logic        uns, rd, wr, expMis;
      for (int it = 0; it < 400; it++) begin
         sz  = 2'($urandom_range(0, 3));
         a   = 32'($urandom_range(0, 4 * MEMB - 1));
         if ($urandom_range(0, 9) < 7 && sz != 2'b11) a = a & ~32'(accBytes(sz) - 1);
         uns = 1'($urandom_range(0, 1));
         rd  = 1'($urandom_range(0, 1));
         wr  = 1'($urandom_range(0, 1));
         d   = $urandom;
         drive(a, sz, uns, rd, wr, d);
         #1;
         exp    = mdlLoad(a, sz, uns);
         expMis = mdlMisaligned(a, sz);
         nVectors++;
         if (RData !== exp) begin
            nMiscompares++;
            $display("FAIL rand_rdata @%h sz%0d u%b: got %h expected %h", a, sz, uns, RData, exp);
         end
         nVectors++;
         if (Misaligned !== expMis) begin
            nMiscompares++;
            $display("FAIL rand_misaligned @%h sz%0d: got %b expected %b", a, sz, Misaligned, expMis);
         end
         mdlCommit(a, sz, rd, wr, d);
         step();
         nVectors++;
         if (Fault !== mdlFault) begin
            nMiscompares++; $display("FAIL rand_fault: got %b expected %b", Fault, mdlFault);
         end
         nVectors++;
         if (Test_value !== mdlTestValue()) begin
            nMiscompares++;
            $display("FAIL rand_test_value: got %h expected %h", Test_value, mdlTestValue());
         end
      end
      idle();
   endtask

   initial begin
      $display("[TB] starting data_mem_byte bench");
      test_reset();
      test_init();
      test_byte_lanes();
      test_half();
      test_misalign();
      test_init();
      test_wrap();
`ifdef DATA_MEM_CLEAR_EN
      test_sweep();
      test_init();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_byte.md
# data_mem_byte

Byte-addressable, parametrised data memory for the single-cycle MIPS datapath, serving LW/LH/LHU/LB/LBU/SW/SH/SB. It has byte-lane write enables, load sign/zero extension, alignment checking with a sticky fault flag, and a post-reset clear engine that sweeps the array one word per cycle. It sits between the ALU address output and the write-back mux.

## Interface
- WIDTH, 32: word width in bits; legal values 32 or 64.
- DEPTH, 128: number of words; power of two.
- AD_WIDTH, 32: byte-address width.
- TEST_WIDTH, 16: width of Test_value (≤ WIDTH).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge.
- Res  in  1  synchronous active-high reset.
- Address  in  AD_WIDTH  byte address.
- WData  in  WIDTH  store data, right-justified.
- Size  in  2  00 byte, 01 half, 10 word (32b), 11 double (WIDTH=64 only).
- Unsigned  in  1  1 = zero-extend load, 0 = sign-extend.
- Rd_En  in  1  load in progress (fault checking only).
- Wr_En  in  1  store request.
- RData  out  WIDTH  extended load data, combinational.
- Busy  out  1  clear sweep active; accesses ignored.
- Misaligned  out  1  combinational: current access is misaligned or has an illegal Size.
- Fault  out  1  sticky error flag.
- Test_value  out  TEST_WIDTH  low bits of word 0.

## Operation
- Word index = Address[OFS+IDX-1:OFS], where OFS = log2(WIDTH/8) and IDX = log2(DEPTH). Upper address bits are ignored, so addresses wrap modulo DEPTH·WIDTH/8.
- Lane = Address[OFS-1:0]. Alignment rules:
  - Half requires lane[0]=0.
  - Word requires lane[1:0]=0.
  - Double requires lane=0 and WIDTH=64.
  - Size=11 with WIDTH=32 is illegal.
- Store writes only the addressed lanes. WData's low bytes are steered to those lanes. Other lanes are unchanged.
- Load selects the addressed bytes, shifts them to bit 0, and extends to WIDTH per Unsigned. Word loads on WIDTH=64 extend from bit 31.
- Misaligned/illegal store: no array write; Fault sets.
- Misaligned/illegal load: RData = 0; Fault sets if Rd_En.
- Fault is sticky and cleared only by Res.
- State machine (2 states):
  - CLEAR: Busy=1, RData=0, Wr_En ignored, Fault not updated. Each cycle writes 0 to word[cnt] and increments cnt. After word DEPTH-1 → READY.
  - READY: normal access.
- Res high → state CLEAR, cnt=0, Fault=0, regardless of current state (a reset mid-sweep restarts the sweep).

## Timing
- Reset values: Busy=1, Fault=0, RData=0, Misaligned = f(inputs), Test_value reflects array contents (word 0 is zeroed on the first sweep cycle).
- While Res is held: cnt stays 0 and word 0 is rewritten to 0 each cycle.
- After Res falls: Busy stays high for exactly DEPTH rising edges, then drops to 0.
- Store: takes effect at the rising edge where Wr_En=1, Busy=0, and the access is aligned.
- Load: combinational, zero latency.
- Read-during-write to the same word returns old data in that cycle and new data after the edge.
- Test_value updates on the edge after a store to word 0.

## Configuration
- DATA_MEM_CLEAR_EN defined: clear engine present as described.
- DATA_MEM_CLEAR_EN undefined:
  - No sweep; Busy tied 0 and state fixed at READY.
  - Res clears only Fault.
  - Array contents after reset are undefined; the bench must not check them.

## Structure
- Package data_mem_pkg holds:
  - Size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DOUBLE.
  - The state enum {ST_CLEAR, ST_READY}.
  - An alignment-check function.
- One combinational sub-module, data_mem_lane_align. It generates byte-lane write enables and steered write data, and performs load extraction with extension.
- The top level holds the array, the clear FSM/counter, and Fault.

## Test plan
- Reset sweep: Res high 3 cycles, then low; Busy=1 for 128 cycles then 0. A preceding SW of 0xDEADBEEF to addr 0x10 reads back 0 after the sweep.
- Byte lanes: SW 0x11223344 @0x20, SB 0xAA @0x21 → LW = 0x1122AA44. LB @0x21 = 0xFFFFFFAA; LBU @0x21 = 0x000000AA.
- Half: SH 0x8001 @0x42 over 0 → LW 0x80010000. LH @0x42 = 0xFFFF8001; LHU = 0x00008001.
- Misalignment: SW @0x23 → memory unchanged, Misaligned=1, Fault=1 next cycle and stays 1 until Res. LH @0x21 → RData=0.
- Wrap and test port: SW 0x0000BEEF @0x200 (wraps to word 0) → Test_value=0xBEEF. Wr_En during Busy → no write.
- Reset mid-sweep: Res pulse at sweep cycle 50 → Busy stays high for another 128 cycles after release.
